// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the multiply sequencer: ALU opcodes and sequencer states.
package alu_mul_seq_pkg;

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_NOR = 4'd3;

    typedef enum logic [2:0] {
        MS_IDLE   = 3'd0,
        MS_ABS_A  = 3'd1,
        MS_ABS_B  = 3'd2,
        MS_ITER   = 3'd3,
        MS_NEG_LO = 3'd4,
        MS_NEG_HI = 3'd5,
        MS_DONE   = 3'd6
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Multi-cycle 32x32 -> 64 multiply sequencer that borrows the shared execute-stage ALU
// for sign correction and shift-add iterations.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_signed,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    output logic [31:0] rsp_hi,
    output logic [31:0] rsp_lo,
    output logic        alu_own,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_c
);

    localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

    mul_state_t  state, next_state;
    logic [31:0] mcand, hi, lo;
    logic [4:0]  cnt;
    logic        neg, sgn, lo_zero, carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= MS_IDLE;
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            sgn     <= 1'b0;
            lo_zero <= 1'b0;
            rsp_hi  <= '0;
            rsp_lo  <= '0;
        end else begin
            state <= next_state;
            case (state)
                MS_IDLE: begin
                    if (req_valid) begin
                        mcand <= req_a;
                        lo    <= req_b;
                        hi    <= '0;
                        neg   <= req_signed & (req_a[31] ^ req_b[31]);
                        sgn   <= req_signed;
                        cnt   <= '0;
                    end
                end
                MS_ABS_A: mcand <= alu_c;
                MS_ABS_B: lo <= alu_c;
                MS_ITER: begin
                    // Shift {carry, sum, lo} right by one: the sum's LSB drops into lo.
                    hi  <= {carry, alu_c[31:1]};
                    lo  <= {alu_c[0], lo[31:1]};
                    cnt <= cnt + 5'd1;
                end
                MS_NEG_LO: begin
                    lo      <= alu_c;
                    lo_zero <= (lo == 32'd0);
                end
                MS_NEG_HI: begin
                    hi     <= alu_c;
                    rsp_hi <= alu_c;
                    rsp_lo <= lo;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = ALU_NOP;
        carry      = 1'b0;
        case (state)
            MS_IDLE: begin
                if (req_valid) next_state = MS_ABS_A;
            end
            MS_ABS_A: begin
                if (sgn && mcand[31]) begin
                    alu_op = ALU_SUB;
                    alu_b  = mcand;
                end else begin
                    alu_a = mcand;
                end
                next_state = MS_ABS_B;
            end
            MS_ABS_B: begin
                // 0x80000000 negates to itself, which reads correctly as unsigned 2^31.
                if (sgn && lo[31]) begin
                    alu_op = ALU_SUB;
                    alu_b  = lo;
                end else begin
                    alu_a = lo;
                end
                next_state = MS_ITER;
            end
            MS_ITER: begin
                alu_a = hi;
                if (lo[0]) begin
                    alu_op = ALU_ADD;
                    alu_b  = mcand;
                    carry  = (alu_c < hi);
                end
                if (cnt == LAST_ITER) next_state = MS_NEG_LO;
            end
            MS_NEG_LO: begin
                if (neg) begin
                    alu_op = ALU_SUB;
                    alu_b  = lo;
                end else begin
                    alu_a = lo;
                end
                next_state = MS_NEG_HI;
            end
            MS_NEG_HI: begin
                // A borrow only propagates into hi when the low word negated to zero.
                if (neg && lo_zero) begin
                    alu_op = ALU_SUB;
                    alu_b  = hi;
                end else if (neg) begin
                    alu_op = ALU_NOR;
                    alu_a  = hi;
                end else begin
                    alu_a = hi;
                end
                next_state = MS_DONE;
            end
            MS_DONE: next_state = MS_IDLE;
            default: next_state = MS_IDLE;
        endcase
    end

    assign req_ready = (state == MS_IDLE);
    assign rsp_valid = (state == MS_DONE);
    assign alu_own   = (state != MS_IDLE) && (state != MS_DONE);

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed self-checking bench for alu_mul_seq with a behavioural shared ALU.
module tb_alu_mul_seq;
    import alu_mul_seq_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_signed;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic [31:0] rsp_hi;
    logic [31:0] rsp_lo;
    logic        alu_own;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_c;

    int compared;
    int mismatched;

    alu_mul_seq #(.ITER(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_signed (req_signed),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_hi     (rsp_hi),
        .rsp_lo     (rsp_lo),
        .alu_own    (alu_own),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_c      (alu_c)
    );

    // Stand-in for the shared execute-stage ALU
    always_comb begin
        case (alu_op)
            ALU_ADD: alu_c = alu_a + alu_b;
            ALU_SUB: alu_c = alu_a - alu_b;
            ALU_NOR: alu_c = ~(alu_a | alu_b);
            ALU_NOP: alu_c = alu_a;
            default: alu_c = 32'd0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Issues one multiply from a negedge, checks latency, result and handshake, ends on a negedge.
    task automatic applyStimulus(input string tag, input logic sgn, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp_hi,
                                 input logic [31:0] exp_lo);
        int cycles;
        int guard;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        req_valid  = 1'b1;
        req_signed = sgn;
        req_a      = a;
        req_b      = b;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput({tag, "_own_busy"}, 64'(alu_own), 64'd1);
        checkOutput({tag, "_ready_busy"}, 64'(req_ready), 64'd0);
        cycles = 1;
        while (!rsp_valid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "_latency"}, 64'(cycles), 64'd37);
        checkOutput({tag, "_product"}, {rsp_hi, rsp_lo}, {exp_hi, exp_lo});
        checkOutput({tag, "_ready_done"}, 64'(req_ready), 64'd0);
        checkOutput({tag, "_own_done"}, 64'(alu_own), 64'd0);
        @(negedge clk);
        checkOutput({tag, "_ready_idle"}, 64'(req_ready), 64'd1);
        checkOutput({tag, "_valid_pulse"}, 64'(rsp_valid), 64'd0);
        checkOutput({tag, "_held"}, {rsp_hi, rsp_lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        int cycles;
        logic [63:0] first_prod;
        logic seen_first;
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_signed = 1'b0;
        req_a      = '0;
        req_b      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", 64'(req_ready), 64'd1);
        checkOutput("rst_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_rsp", {rsp_hi, rsp_lo}, 64'd0);
        checkOutput("rst_own", 64'(alu_own), 64'd0);
        checkOutput("rst_alu", {alu_a, alu_b}, 64'd0);
        checkOutput("rst_op", 64'(alu_op), 64'(ALU_NOP));
        rst = 1'b0;
        @(negedge clk);

        applyStimulus("multu_3x5",   1'b0, 32'd3,        32'd5,        32'h0000_0000, 32'h0000_000F);
        applyStimulus("multu_max",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        applyStimulus("mult_m1x1",   1'b1, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus("mult_min",    1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        applyStimulus("mult_m3x0",   1'b1, 32'hFFFF_FFFD, 32'd0,        32'h0000_0000, 32'h0000_0000);
        applyStimulus("mult_m7x3",   1'b1, 32'hFFFF_FFF9, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
        applyStimulus("mult_m2xm3",  1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0006);
        applyStimulus("multu_m1x1",  1'b0, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE);

        // Abort in the middle of ITER
        req_valid  = 1'b1;
        req_signed = 1'b0;
        req_a      = 32'd1000;
        req_b      = 32'd1000;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_own", 64'(alu_own), 64'd0);
        checkOutput("abort_ready", 64'(req_ready), 64'd1);
        checkOutput("abort_valid", 64'(rsp_valid), 64'd0);
        checkOutput("abort_rsp", {rsp_hi, rsp_lo}, 64'd0);
        applyStimulus("after_abort", 1'b0, 32'd6, 32'd7, 32'h0000_0000, 32'd42);

        // req_valid held high with a changing multiplicand across a whole busy period
        req_valid  = 1'b1;
        req_signed = 1'b0;
        req_a      = 32'h9ABC_DEF0;
        req_b      = 32'd2;
        @(posedge clk);
        @(negedge clk);
        cycles     = 1;
        seen_first = 1'b0;
        first_prod = '0;
        while (!req_ready && cycles < 100) begin
            req_a = 32'(cycles);
            if (rsp_valid) begin
                seen_first = 1'b1;
                first_prod = {rsp_hi, rsp_lo};
            end
            @(negedge clk);
            cycles++;
        end
        checkOutput("hold_reaccept", 64'(cycles), 64'd38);
        checkOutput("hold_seen", 64'(seen_first), 64'd1);
        checkOutput("hold_product", first_prod, 64'h0000_0001_3579_BDE0);
        req_a = 32'd38;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("hold_second_busy", 64'(alu_own), 64'd1);
        cycles = 1;
        while (!rsp_valid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("hold_second_latency", 64'(cycles), 64'd37);
        checkOutput("hold_second_product", {rsp_hi, rsp_lo}, 64'd76);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
